// File: rtl/time_to_bcd_seq.sv
// Tick count to packed BCD minutes:seconds:milliseconds.
// One shared restoring divider (one quotient bit per cycle) runs three divisions
// back to back; a double-dabble stage then converts all three fields in parallel.
module time_to_bcd_seq #(
    parameter int unsigned     IN_W         = 39,
    parameter longint unsigned TICKS_PER_MS = 100000,
    parameter int unsigned     MIN_DIGITS   = 3,
    localparam int unsigned    OUT_W        = 4*MIN_DIGITS+20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IN_W-1:0]  time_in,
    output logic             busy,
    output logic             valid,
    output logic             ovf,
    output logic [OUT_W-1:0] time_out
);

    localparam int unsigned DV_W    = (IN_W > 16) ? IN_W : 16;
    localparam int unsigned CNT_W   = $clog2(DV_W);
    localparam int unsigned SEC_CYC = 16;
    // Ten shift cycles plus one cycle that hands the finished digits to the output stage.
    localparam int unsigned BCD_CYC = 11;
    localparam int unsigned MAX_MIN = (MIN_DIGITS == 1) ? 9 : (MIN_DIGITS == 2) ? 99 : 999;

    typedef enum logic [2:0] {
        S_IDLE, S_DIV_TICK, S_DIV_MIN, S_DIV_SEC, S_BCD, S_DONE
    } state_t;

    state_t             state, next_state;
    logic [CNT_W-1:0]   cnt;
    logic [IN_W-1:0]    q;
    logic [DV_W-1:0]    rem;
    logic [DV_W-1:0]    dvsr;
    logic [IN_W-1:0]    min_r;
    logic               ovf_r;
    logic [21:0]        dd_min, dd_sec, dd_ms;

    logic [DV_W:0]      rem_sh;
    logic               q_bit;
    logic [DV_W-1:0]    rem_nx;
    logic [IN_W-1:0]    q_nx;
    logic               busy_nx;
    logic               valid_nx;
    logic [OUT_W-1:0]   result_nx;

    // One double-dabble step: add 3 to any digit >= 5, then shift left.
    function automatic logic [21:0] dd_step(input logic [21:0] v);
        logic [21:0] a;
        a = v;
        for (int i = 0; i < 3; i++) begin
            if (a[10+4*i +: 4] >= 4'd5)
                a[10+4*i +: 4] = a[10+4*i +: 4] + 4'd3;
        end
        return {a[20:0], 1'b0};
    endfunction

    // Shared restoring divider step: bring in the next dividend bit, trial subtract.
    always_comb begin
        rem_sh = {rem, q[IN_W-1]};
        q_bit  = (rem_sh >= {1'b0, dvsr});
        rem_nx = q_bit ? DV_W'(rem_sh - {1'b0, dvsr}) : rem_sh[DV_W-1:0];
        q_nx   = {q[IN_W-2:0], q_bit};
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next-state logic; each phase ends on its last counter value.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:     if (start) next_state = S_DIV_TICK;
            S_DIV_TICK: if (cnt == CNT_W'(IN_W-1)) next_state = S_DIV_MIN;
            S_DIV_MIN:  if (cnt == CNT_W'(IN_W-1)) next_state = S_DIV_SEC;
            S_DIV_SEC:  if (cnt == CNT_W'(SEC_CYC-1)) next_state = S_BCD;
            S_BCD:      if (cnt == CNT_W'(BCD_CYC-1)) next_state = S_DONE;
            S_DONE:     next_state = start ? S_DIV_TICK : S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    // Output decode: next-cycle busy/valid and the saturated, packed result.
    always_comb begin
        busy_nx   = (next_state == S_DIV_TICK) || (next_state == S_DIV_MIN) ||
                    (next_state == S_DIV_SEC)  || (next_state == S_BCD);
        valid_nx  = (next_state == S_DONE);
        result_nx = {dd_min[10 +: 4*MIN_DIGITS], dd_sec[17:10], dd_ms[21:10]};
        if (ovf_r)
            result_nx = {{MIN_DIGITS{4'h9}}, 8'h59, 12'h999};
    end

    // Datapath: phase counter, divider operands and double-dabble registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            q      <= '0;
            rem    <= '0;
            dvsr   <= '0;
            min_r  <= '0;
            ovf_r  <= 1'b0;
            dd_min <= '0;
            dd_sec <= '0;
            dd_ms  <= '0;
        end else begin
            cnt <= (next_state != state || state == S_IDLE) ? '0 : cnt + 1'b1;
            case (state)
                S_IDLE, S_DONE: begin
                    if (next_state == S_DIV_TICK) begin
                        q    <= time_in;
                        rem  <= '0;
                        dvsr <= DV_W'(TICKS_PER_MS);
                    end
                end
                S_DIV_TICK: begin
                    q <= q_nx;
                    if (next_state == S_DIV_MIN) begin
                        rem  <= '0;
                        dvsr <= DV_W'(60000);
                    end else begin
                        rem <= rem_nx;
                    end
                end
                S_DIV_MIN: begin
                    if (next_state == S_DIV_SEC) begin
                        min_r <= q_nx;
                        // Remainder < 60000: left-align its 16 bits for a 16-step divide.
                        q     <= IN_W'(rem_nx[15:0]) << (IN_W - 16);
                        rem   <= '0;
                        dvsr  <= DV_W'(1000);
                    end else begin
                        q   <= q_nx;
                        rem <= rem_nx;
                    end
                end
                S_DIV_SEC: begin
                    if (next_state == S_BCD) begin
                        ovf_r  <= (min_r > IN_W'(MAX_MIN));
                        dd_min <= {12'd0, min_r[9:0]};
                        dd_sec <= {12'd0, q_nx[9:0]};
                        dd_ms  <= {12'd0, rem_nx[9:0]};
                    end else begin
                        q   <= q_nx;
                        rem <= rem_nx;
                    end
                end
                S_BCD: begin
                    if (cnt < CNT_W'(BCD_CYC-1)) begin
                        dd_min <= dd_step(dd_min);
                        dd_sec <= dd_step(dd_sec);
                        dd_ms  <= dd_step(dd_ms);
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered outputs; result and ovf only change when entering DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            valid    <= 1'b0;
            ovf      <= 1'b0;
            time_out <= '0;
        end else begin
            busy  <= busy_nx;
            valid <= valid_nx;
            if (valid_nx) begin
                ovf      <= ovf_r;
                time_out <= result_nx;
            end
        end
    end

endmodule

// File: tb/tb_time_to_bcd_seq.sv
// Bench for time_to_bcd_seq: arithmetic reference model, per-cycle scoreboard on the
// default instance, directed literal cases on default and two re-parameterised instances.
module tb_time_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start = 1'b0;
    logic [38:0] time_in = '0;
    logic        busy, valid, ovf;
    logic [31:0] time_out;

    logic        start_m1 = 1'b0;
    logic [38:0] tin_m1 = '0;
    logic        busy_m1, valid_m1, ovf_m1;
    logic [23:0] out_m1;

    logic        start_t1 = 1'b0;
    logic [23:0] tin_t1 = '0;
    logic        busy_t1, valid_t1, ovf_t1;
    logic [31:0] out_t1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    time_to_bcd_seq dut (
        .clk(clk), .rst(rst), .start(start), .time_in(time_in),
        .busy(busy), .valid(valid), .ovf(ovf), .time_out(time_out)
    );

    time_to_bcd_seq #(.MIN_DIGITS(1)) dut_m1 (
        .clk(clk), .rst(rst), .start(start_m1), .time_in(tin_m1),
        .busy(busy_m1), .valid(valid_m1), .ovf(ovf_m1), .time_out(out_m1)
    );

    time_to_bcd_seq #(.IN_W(24), .TICKS_PER_MS(1)) dut_t1 (
        .clk(clk), .rst(rst), .start(start_t1), .time_in(tin_t1),
        .busy(busy_t1), .valid(valid_t1), .ovf(ovf_t1), .time_out(out_t1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] bcd3(input longint unsigned x);
        return {4'(x / 100 % 10), 4'(x / 10 % 10), 4'(x % 10)};
    endfunction

    // Reference: plain integer division, saturation, decimal digit extraction.
    function automatic logic [32:0] ref_conv(input longint unsigned t,
                                             input longint unsigned tpm, input int md);
        longint unsigned tot, mins, r, s, ms, maxm;
        logic [31:0] o;
        logic f;
        tot  = t / tpm;
        mins = tot / 60000;
        r    = tot % 60000;
        s    = r / 1000;
        ms   = r % 1000;
        maxm = (md == 1) ? 9 : (md == 2) ? 99 : 999;
        f    = (mins > maxm);
        if (f) begin
            mins = maxm; s = 59; ms = 999;
        end
        o = (32'(bcd3(mins)) << 20) | (32'(bcd3(s)) << 12) | 32'(bcd3(ms));
        return {f, o};
    endfunction

    // Scoreboard for the default instance: predicts acceptance, busy, valid and held result.
    initial begin : scoreboard
        longint cyc, free_at, valid_at, busy_end;
        logic [32:0] pend, held;
        logic p_start, p_rst;
        logic [38:0] p_tin;
        cyc = 0; free_at = 0; valid_at = -1; busy_end = -1;
        pend = '0; held = '0; p_start = 1'b0; p_rst = 1'b1; p_tin = '0;
        forever begin
            @(negedge clk);
            if (rst || p_rst) begin
                cyc = 0; free_at = 0; valid_at = -1; busy_end = -1; held = '0;
                chk("reset busy", 64'(busy), 64'd0);
                chk("reset valid", 64'(valid), 64'd0);
                chk("reset ovf", 64'(ovf), 64'd0);
                chk("reset time_out", 64'(time_out), 64'd0);
            end else begin
                cyc++;
                if (p_start && cyc >= free_at) begin
                    pend     = ref_conv(64'(p_tin), 64'd100000, 3);
                    busy_end = cyc + 104;
                    valid_at = cyc + 105;
                    free_at  = cyc + 106;
                end
                if (cyc == valid_at) held = pend;
                chk("sb valid", 64'(valid), 64'(cyc == valid_at));
                chk("sb busy", 64'(busy), 64'(cyc <= busy_end));
                chk("sb time_out", 64'(time_out), 64'(held[31:0]));
                chk("sb ovf", 64'(ovf), 64'(held[32]));
            end
            p_start = start; p_tin = time_in; p_rst = rst;
        end
    end

    // Start one conversion on the selected instance and check latency and result.
    task automatic run_dir(input int sel, input logic [63:0] tin, input logic [31:0] exp_out,
                           input logic exp_ovf, input int exp_lat, input string name);
        int n;
        logic v, b, f;
        logic [31:0] o;
        case (sel)
            0: begin start = 1'b1; time_in = 39'(tin); end
            1: begin start_m1 = 1'b1; tin_m1 = 39'(tin); end
            default: begin start_t1 = 1'b1; tin_t1 = 24'(tin); end
        endcase
        @(posedge clk); #2;
        start = 1'b0; start_m1 = 1'b0; start_t1 = 1'b0;
        n = 0;
        v = 1'b0; b = 1'b0; f = 1'b0; o = '0;
        while (n < 200) begin
            case (sel)
                0: begin v = valid; b = busy; f = ovf; o = time_out; end
                1: begin v = valid_m1; b = busy_m1; f = ovf_m1; o = {8'h00, out_m1}; end
                default: begin v = valid_t1; b = busy_t1; f = ovf_t1; o = out_t1; end
            endcase
            if (v) break;
            @(posedge clk); #2;
            n++;
        end
        chk({name, " latency"}, 64'(n), 64'(exp_lat));
        chk({name, " busy at valid"}, 64'(b), 64'd0);
        chk({name, " time_out"}, 64'(o), 64'(exp_out));
        chk({name, " ovf"}, 64'(f), 64'(exp_ovf));
        @(posedge clk); #2;
    endtask

    initial begin : driver
        logic [63:0] max39;
        max39 = (64'd1 << 39) - 64'd1;

        // Reference model pinned to hand-computed values.
        chk("model 6123400000", 64'(ref_conv(64'd6123400000, 64'd100000, 3)), 64'h0_00101234);
        chk("model 99999", 64'(ref_conv(64'd99999, 64'd100000, 3)), 64'h0_00000000);
        chk("model max39", 64'(ref_conv(max39, 64'd100000, 3)), 64'h0_09137558);
        chk("model min1 sat", 64'(ref_conv(max39, 64'd100000, 1)), 64'h1_00959999);
        chk("model tpm1", 64'(ref_conv(64'd3599999, 64'd1, 3)), 64'h0_05959999);

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        chk("post-reset busy", 64'(busy), 64'd0);
        chk("post-reset valid", 64'(valid), 64'd0);
        chk("post-reset time_out", 64'(time_out), 64'd0);
        chk("post-reset ovf", 64'(ovf), 64'd0);

        // Reset in the middle of the minutes division aborts the conversion.
        start = 1'b1; time_in = 39'(64'd6123400000);
        @(posedge clk); #2 start = 1'b0;
        repeat (60) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        chk("abort busy", 64'(busy), 64'd0);
        repeat (120) @(posedge clk);
        #2;
        chk("abort time_out", 64'(time_out), 64'd0);
        chk("abort ovf", 64'(ovf), 64'd0);

        // Directed literal cases.
        run_dir(0, 64'd6123400000, 32'h00101234, 1'b0, 105, "d 1:01.234");
        run_dir(0, 64'd99999, 32'h00000000, 1'b0, 105, "d 99999");
        run_dir(0, max39, 32'h09137558, 1'b0, 105, "d max39");
        run_dir(1, max39, 32'h00959999, 1'b1, 105, "m1 max39");
        run_dir(1, 64'd59999900000, 32'h00959999, 1'b0, 105, "m1 9:59.999");
        run_dir(1, 64'd60000000000, 32'h00959999, 1'b1, 105, "m1 10:00.000");
        run_dir(2, 64'd3599999, 32'h05959999, 1'b0, 75, "t1 59:59.999");
        run_dir(2, 64'd16777215, 32'h27937215, 1'b0, 75, "t1 max24");

        // Start held high with time_in changing every cycle.
        for (int i = 0; i < 1300; i++) begin
            start = 1'b1;
            time_in = 39'({$urandom, $urandom});
            @(posedge clk); #2;
        end
        // Sparse random starts.
        for (int i = 0; i < 1300; i++) begin
            start = ($urandom_range(0, 7) == 0);
            time_in = ($urandom_range(0, 3) == 0) ? 39'(max39 - 64'($urandom_range(0, 1000)))
                                                  : 39'({$urandom, $urandom});
            @(posedge clk); #2;
        end
        start = 1'b0;
        repeat (130) @(posedge clk);
        #2;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
